kmeans_centroid_update_k3_d4: RTL and testbench

//  Downstream end of the k=3, d=4 assignment pipeline: consumes each classified point and its selected centroid.

---
 rtl/kmeans_centroid_update_k3_d4_pkg.sv | 24 ++
 rtl/kmeans_seq_divider.sv | 62 ++++++
 rtl/kmeans_centroid_update_k3_d4.sv | 170 +++++++++++++++++
 tb/tb_kmeans_centroid_update_k3_d4.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_centroid_update_k3_d4_pkg.sv
// Shared definitions for the k=3, d=4 centroid update block: geometry, FSM states
// and the fixed iteration-end latency.
package kmeans_centroid_update_k3_d4_pkg;

  localparam int K     = 3;
  localparam int D     = 4;
  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] K_LAST = 2'd2;
  localparam logic [IDX_W-1:0] D_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DIVIDE,
    ST_DONE
  } state_e;

  // Cycles from the accepting edge of the last point to the done pulse.
  function automatic int div_latency(input int acc_width);
    return K * D * (acc_width + 2);
  endfunction

endpackage

// File: rtl/kmeans_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The done pulse appears
// ACC_WIDTH+1 cycles after the start cycle.
module kmeans_seq_divider #(
  parameter int ACC_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ACC_WIDTH-1:0]   dividend,
  input  logic [COUNT_WIDTH-1:0] divisor,
  output logic                   done,
  output logic [OUT_WIDTH-1:0]   quotient
);

  localparam int SW = $clog2(ACC_WIDTH + 1);

  logic [ACC_WIDTH-1:0]   quo;
  logic [COUNT_WIDTH-1:0] rem;
  logic [COUNT_WIDTH-1:0] dvs;
  logic [SW-1:0]          steps;
  logic                   running;
  logic [COUNT_WIDTH:0]   shifted;
  logic                   geq;

  // The remainder stays below the divisor, so one extra bit holds the shifted value.
  assign shifted  = {rem, quo[ACC_WIDTH-1]};
  assign geq      = shifted >= {1'b0, dvs};
  assign quotient = quo[OUT_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      steps   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo     <= dividend;
        rem     <= '0;
        dvs     <= divisor;
        steps   <= SW'(ACC_WIDTH);
        running <= 1'b1;
      end else if (running) begin
        rem   <= geq ? COUNT_WIDTH'(shifted - {1'b0, dvs}) : COUNT_WIDTH'(shifted);
        quo   <= {quo[ACC_WIDTH-2:0], geq};
        steps <= steps - 1'b1;
        if (steps == SW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kmeans_centroid_update_k3_d4.sv
// k-means centroid update (k=3, d=4): accumulate classified points, then divide sums by
// counts with one shared divider. Define KMEANS_ROUND_EN for round-half-up means.
module kmeans_centroid_update_k3_d4
  import kmeans_centroid_update_k3_d4_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 16,
  parameter int COUNT_WIDTH      = 16,
  parameter int ACC_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init_we,
  input  logic [1:0]                  init_idx,
  input  logic [1:0]                  init_dim,
  input  logic [INPUT_DATA_WIDTH-1:0] init_data,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data0,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data1,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data2,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data3,
  input  logic [1:0]                  selected_centroid,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d0,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d1,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d2,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d3,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d0,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d1,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d2,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d3,
  output logic [INPUT_DATA_WIDTH-1:0] centroid2_d0,
  output logic [INPUT_DATA_WIDTH-1:0] centroid2_d1,
  output logic [INPUT_DATA_WIDTH-1:0] centroid2_d2,
  output logic [INPUT_DATA_WIDTH-1:0] centroid2_d3,
  output logic                        busy,
  output logic                        done,
  output logic                        err_idx,
  output logic                        err_ovf
);

  state_e                      state;
  logic [INPUT_DATA_WIDTH-1:0] cent [K][D];
  logic [ACC_WIDTH-1:0]        sum  [K][D];
  logic [COUNT_WIDTH-1:0]      cnt  [K];
  logic [INPUT_DATA_WIDTH-1:0] pt   [D];
  logic [IDX_W-1:0]            slot_k, slot_d;
  logic                        load_pending;
  logic [ACC_WIDTH-1:0]        div_dividend;
  logic                        div_done;
  logic [INPUT_DATA_WIDTH-1:0] div_quo;

  assign pt[0] = input_data0;
  assign pt[1] = input_data1;
  assign pt[2] = input_data2;
  assign pt[3] = input_data3;

  assign in_ready = (state == ST_ACCUM);
  assign busy     = (state != ST_IDLE);

`ifdef KMEANS_ROUND_EN
  assign div_dividend = sum[slot_k][slot_d] + ACC_WIDTH'(cnt[slot_k] >> 1);
`else
  assign div_dividend = sum[slot_k][slot_d];
`endif

  kmeans_seq_divider #(
    .ACC_WIDTH  (ACC_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH),
    .OUT_WIDTH  (INPUT_DATA_WIDTH)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (load_pending),
    .dividend(div_dividend),
    .divisor (cnt[slot_k]),
    .done    (div_done),
    .quotient(div_quo)
  );

  // NOTE: the sum/count/centroid arrays are reset with the rest of the state because an
  // abort must discard partial sums and return the published centroids to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      slot_k       <= '0;
      slot_d       <= '0;
      load_pending <= 1'b0;
      done         <= 1'b0;
      err_idx      <= 1'b0;
      err_ovf      <= 1'b0;
      for (int k = 0; k < K; k++) begin
        cnt[k] <= '0;
        for (int d = 0; d < D; d++) begin
          cent[k][d] <= '0;
          sum[k][d]  <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (init_we && init_idx <= K_LAST) cent[init_idx][init_dim] <= init_data;
          if (start) begin
            for (int k = 0; k < K; k++) begin
              cnt[k] <= '0;
              for (int d = 0; d < D; d++) sum[k][d] <= '0;
            end
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            if (selected_centroid > K_LAST) begin
              err_idx <= 1'b1;
            end else if (cnt[selected_centroid] == '1) begin
              err_ovf <= 1'b1;
            end else begin
              for (int d = 0; d < D; d++)
                sum[selected_centroid][d] <= sum[selected_centroid][d] + ACC_WIDTH'(pt[d]);
              cnt[selected_centroid] <= cnt[selected_centroid] + 1'b1;
            end
            if (in_last) begin
              state        <= ST_DIVIDE;
              slot_k       <= '0;
              slot_d       <= '0;
              load_pending <= 1'b1;
            end
          end
        end
        ST_DIVIDE: begin
          if (load_pending) load_pending <= 1'b0;
          // Empty clusters still run their slot so the iteration latency is fixed.
          if (div_done) begin
            if (cnt[slot_k] != '0) cent[slot_k][slot_d] <= div_quo;
            if (slot_k == K_LAST && slot_d == D_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              if (slot_d == D_LAST) begin
                slot_d <= '0;
                slot_k <= slot_k + 1'b1;
              end else begin
                slot_d <= slot_d + 1'b1;
              end
              load_pending <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign centroid0_d0 = cent[0][0];
  assign centroid0_d1 = cent[0][1];
  assign centroid0_d2 = cent[0][2];
  assign centroid0_d3 = cent[0][3];
  assign centroid1_d0 = cent[1][0];
  assign centroid1_d1 = cent[1][1];
  assign centroid1_d2 = cent[1][2];
  assign centroid1_d3 = cent[1][3];
  assign centroid2_d0 = cent[2][0];
  assign centroid2_d1 = cent[2][1];
  assign centroid2_d2 = cent[2][2];
  assign centroid2_d3 = cent[2][3];

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d4.sv
// Bench for kmeans_centroid_update_k3_d4: a default instance and a 2-bit-counter instance
// share stimulus and are compared every cycle against a transaction-level model.
module tb_kmeans_centroid_update_k3_d4;

`ifdef KMEANS_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam int unsigned CMAX[2] = '{65535, 3};
  localparam int          LAT[2]  = '{408, 240};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_we = 1'b0;
  logic [1:0] init_idx = '0, init_dim = '0, sel = '0;
  logic [15:0] init_data = '0;
  logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [3:0][15:0] in_data = '0;

  logic [1:0] o_ready, o_busy, o_done, o_erri, o_erro;
  logic [1:0][2:0][3:0][15:0] o_c;

  always #5 clk = ~clk;

  kmeans_centroid_update_k3_d4 dut_a (
    .clk(clk), .rst(rst), .init_we(init_we), .init_idx(init_idx), .init_dim(init_dim),
    .init_data(init_data), .start(start), .in_valid(in_valid), .in_ready(o_ready[0]),
    .in_last(in_last), .input_data0(in_data[0]), .input_data1(in_data[1]),
    .input_data2(in_data[2]), .input_data3(in_data[3]), .selected_centroid(sel),
    .centroid0_d0(o_c[0][0][0]), .centroid0_d1(o_c[0][0][1]), .centroid0_d2(o_c[0][0][2]),
    .centroid0_d3(o_c[0][0][3]), .centroid1_d0(o_c[0][1][0]), .centroid1_d1(o_c[0][1][1]),
    .centroid1_d2(o_c[0][1][2]), .centroid1_d3(o_c[0][1][3]), .centroid2_d0(o_c[0][2][0]),
    .centroid2_d1(o_c[0][2][1]), .centroid2_d2(o_c[0][2][2]), .centroid2_d3(o_c[0][2][3]),
    .busy(o_busy[0]), .done(o_done[0]), .err_idx(o_erri[0]), .err_ovf(o_erro[0])
  );

  kmeans_centroid_update_k3_d4 #(.COUNT_WIDTH(2), .ACC_WIDTH(18)) dut_b (
    .clk(clk), .rst(rst), .init_we(init_we), .init_idx(init_idx), .init_dim(init_dim),
    .init_data(init_data), .start(start), .in_valid(in_valid), .in_ready(o_ready[1]),
    .in_last(in_last), .input_data0(in_data[0]), .input_data1(in_data[1]),
    .input_data2(in_data[2]), .input_data3(in_data[3]), .selected_centroid(sel),
    .centroid0_d0(o_c[1][0][0]), .centroid0_d1(o_c[1][0][1]), .centroid0_d2(o_c[1][0][2]),
    .centroid0_d3(o_c[1][0][3]), .centroid1_d0(o_c[1][1][0]), .centroid1_d1(o_c[1][1][1]),
    .centroid1_d2(o_c[1][1][2]), .centroid1_d3(o_c[1][1][3]), .centroid2_d0(o_c[1][2][0]),
    .centroid2_d1(o_c[1][2][1]), .centroid2_d2(o_c[1][2][2]), .centroid2_d3(o_c[1][2][3]),
    .busy(o_busy[1]), .done(o_done[1]), .err_idx(o_erri[1]), .err_ovf(o_erro[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one record per instance, updated per clock edge from the bench inputs.
  typedef enum int {M_IDLE, M_ACC, M_DIV, M_DONE} mode_e;
  mode_e           m_mode [2];
  int              m_left [2];
  int unsigned     m_cent [2][3][4];
  int unsigned     m_next [2][3][4];
  longint unsigned m_sum  [2][3][4];
  int unsigned     m_cnt  [2][3];
  bit              m_erri [2];
  bit              m_erro [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_left[i] = 0; m_erri[i] = 0; m_erro[i] = 0;
      for (int k = 0; k < 3; k++) begin
        m_cnt[i][k] = 0;
        for (int d = 0; d < 4; d++) begin
          m_cent[i][k][d] = 0; m_next[i][k][d] = 0; m_sum[i][k][d] = 0;
        end
      end
    end
  endtask

  task automatic model_step(input int i);
    longint unsigned q;
    case (m_mode[i])
      M_IDLE: begin
        if (init_we && init_idx < 3) m_cent[i][init_idx][init_dim] = init_data;
        if (start) begin
          for (int k = 0; k < 3; k++) begin
            m_cnt[i][k] = 0;
            for (int d = 0; d < 4; d++) m_sum[i][k][d] = 0;
          end
          m_mode[i] = M_ACC;
        end
      end
      M_ACC: if (in_valid) begin
        if (sel == 2'd3) m_erri[i] = 1;
        else if (m_cnt[i][sel] == CMAX[i]) m_erro[i] = 1;
        else begin
          for (int d = 0; d < 4; d++) m_sum[i][sel][d] += in_data[d];
          m_cnt[i][sel]++;
        end
        if (in_last) begin
          for (int k = 0; k < 3; k++)
            for (int d = 0; d < 4; d++)
              if (m_cnt[i][k] == 0) m_next[i][k][d] = m_cent[i][k][d];
              else begin
                q = (m_sum[i][k][d] + (ROUND ? m_cnt[i][k] / 2 : 0)) / m_cnt[i][k];
                m_next[i][k][d] = int'(q & 64'hFFFF);
              end
          m_mode[i] = M_DIV;
          m_left[i] = LAT[i];
        end
      end
      M_DIV: begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_cent[i] = m_next[i];
          m_mode[i] = M_DONE;
        end
      end
      default: m_mode[i] = M_IDLE;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      cyc++;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Centroids are only defined outside DIVIDE, where writes land one element at a time.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy%0d", i),  32'(o_busy[i]),  32'(m_mode[i] != M_IDLE));
      check($sformatf("done%0d", i),  32'(o_done[i]),  32'(m_mode[i] == M_DONE));
      check($sformatf("ready%0d", i), 32'(o_ready[i]), 32'(m_mode[i] == M_ACC));
      check($sformatf("err_idx%0d", i), 32'(o_erri[i]), 32'(m_erri[i]));
      check($sformatf("err_ovf%0d", i), 32'(o_erro[i]), 32'(m_erro[i]));
      if (m_mode[i] != M_DIV)
        for (int k = 0; k < 3; k++)
          for (int d = 0; d < 4; d++)
            check($sformatf("c%0d_k%0d_d%0d", i, k, d), 32'(o_c[i][k][d]), m_cent[i][k][d]);
    end
  end

  logic [63:0] q_pts[$];
  logic [1:0]  q_sel[$];
  int acc_cyc;
  int done_cyc[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_write(input logic [1:0] k, input logic [1:0] d, input logic [15:0] v);
    init_we = 1; init_idx = k; init_dim = d; init_data = v;
    tick();
    init_we = 0;
  endtask

  task automatic add_pt(input logic [1:0] s, input logic [15:0] a, b, c, d);
    q_pts.push_back({d, c, b, a});
    q_sel.push_back(s);
  endtask

  // hold_start keeps start high through ACCUM, where it must have no effect.
  task automatic run_iter(input bit gaps, input bit hold_start);
    start = 1;
    tick();
    start = hold_start;
    for (int j = 0; j < q_pts.size(); j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      in_valid = 1; in_data = q_pts[j]; sel = q_sel[j]; in_last = (j == q_pts.size() - 1);
      tick();
      in_valid = 0; in_last = 0;
    end
    start = 0;
    acc_cyc = cyc;
    q_pts.delete();
    q_sel.delete();
  endtask

  task automatic wait_idle();
    done_cyc = '{-1, -1};
    for (int n = 0; n < 1000 && (m_mode[0] != M_IDLE || m_mode[1] != M_IDLE); n++) begin
      tick();
      for (int i = 0; i < 2; i++) if (o_done[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
    end
    check("idle_a", 32'(o_busy[0]), 0);
    check("idle_b", 32'(o_busy[1]), 0);
  endtask

  initial begin
    // Reset state and centroid initialisation.
    repeat (3) tick();
    check("rst_busy", 32'(o_busy[0]), 0);
    check("rst_done", 32'(o_done[0]), 0);
    check("rst_c0", 32'(o_c[0][0][0]), 0);
    rst = 0;
    tick();
    for (int k = 0; k < 3; k++)
      for (int d = 0; d < 4; d++)
        init_write(2'(k), 2'(d), (k == 0) ? 16'd10 : (k == 1) ? 16'd100 : 16'd1000);
    tick();
    check("init_a_c0", 32'(o_c[0][0][3]), 10);
    check("init_a_c1", 32'(o_c[0][1][2]), 100);
    check("init_b_c2", 32'(o_c[1][2][0]), 1000);

    // Mean of two points to cluster 0; other clusters empty.
    add_pt(0, 2, 4, 6, 8);
    add_pt(0, 4, 6, 8, 10);
    run_iter(0, 0);
    wait_idle();
    check("lat_a", 32'(done_cyc[0] - acc_cyc), 408);
    check("lat_b", 32'(done_cyc[1] - acc_cyc), 240);
    for (int d = 0; d < 4; d++) begin
      check("mean_a_c0", 32'(o_c[0][0][d]), 32'(3 + 2 * d));
      check("mean_b_c0", 32'(o_c[1][0][d]), 32'(3 + 2 * d));
    end
    check("empty_a_c1", 32'(o_c[0][1][0]), 100);
    check("empty_a_c2", 32'(o_c[0][2][3]), 1000);

    // Rounding of a .5 mean.
    add_pt(1, 1, 1, 1, 1);
    add_pt(1, 2, 2, 2, 2);
    run_iter(1, 0);
    wait_idle();
    check("round_a_c1", 32'(o_c[0][1][0]), ROUND ? 2 : 1);
    check("round_b_c1", 32'(o_c[1][1][3]), ROUND ? 2 : 1);

    // Invalid index and counter saturation on the 2-bit-counter instance.
    add_pt(3, 500, 500, 500, 500);
    add_pt(2, 3, 6, 9, 12);
    add_pt(2, 6, 9, 12, 15);
    add_pt(2, 9, 12, 15, 18);
    add_pt(2, 100, 100, 100, 100);
    run_iter(0, 0);
    wait_idle();
    check("erri_a", 32'(o_erri[0]), 1);
    check("erri_b", 32'(o_erri[1]), 1);
    check("erro_a", 32'(o_erro[0]), 0);
    check("erro_b", 32'(o_erro[1]), 1);
    for (int d = 0; d < 4; d++) check("ovf_b_c2", 32'(o_c[1][2][d]), 32'(6 + 3 * d));

    // Control: valid in IDLE, start in ACCUM/DIVIDE, init during DIVIDE are all ignored.
    in_valid = 1; in_last = 1; sel = 0; in_data = {16'd9, 16'd9, 16'd9, 16'd9};
    repeat (3) tick();
    in_valid = 0; in_last = 0;
    add_pt(1, 50, 60, 70, 80);
    add_pt(1, 70, 80, 90, 100);
    run_iter(1, 1);
    repeat (5) tick();
    for (int n = 0; n < 40; n++) begin
      init_we = 1; init_idx = 2'(n % 3); init_dim = 2'(n % 4); init_data = 16'd7777;
      start = n[0];
      tick();
    end
    init_we = 0; start = 0;
    wait_idle();

    // Abort mid-DIVIDE, then a clean iteration from zeroed centroids.
    add_pt(2, 11, 22, 33, 44);
    run_iter(0, 0);
    repeat (100) tick();
    rst = 1;
    #1;
    check("abort_busy", 32'(o_busy[0]), 0);
    check("abort_c2", 32'(o_c[0][2][1]), 0);
    check("abort_erri", 32'(o_erri[0]), 0);
    tick();
    rst = 0;
    tick();
    init_write(0, 0, 16'd10);
    add_pt(0, 20, 30, 40, 50);
    add_pt(0, 40, 50, 60, 70);
    run_iter(0, 0);
    wait_idle();
    for (int d = 0; d < 4; d++) check("post_abort_c0", 32'(o_c[0][0][d]), 32'(30 + 10 * d));
    check("post_abort_c1", 32'(o_c[0][1][0]), 0);

    // Randomised iterations.
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 4))
        init_write(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
      in_valid = 1; sel = 0; in_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      tick();
      in_valid = 0;
      repeat ($urandom_range(1, 10))
        add_pt(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
               16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_iter(1, 0);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
